integral_image_stream: RTL and testbench
========================================

Name: integral_image_stream

Overview:
- Streaming integral-image generator for the face-detection pipeline. Accepts one pixel per handshake in raster order and emits one integral value per pixel: II(x,y) = sum of p(i,j) for all i<=x, j<=y.
- Parametrised successor to the fixed 20x20 window integrator, with configurable frame size and pixel width.
- Adds valid/ready flow control, a frame state machine, and an optional squared-pixel mode used for variance normalisation.
- Sits between the luminance line feed and the Haar feature evaluator.

Parameters:
- IMG_W, 20, pixels per row (>=2).
- IMG_H, 20, rows per frame (>=2).
- PIX_W, 8, input pixel width (unsigned).
- SQUARED, 0, 1 = accumulate p*p instead of p.
- ACC_W, derived localparam (not overridable): (SQUARED ? 2*PIX_W : PIX_W) + clog2(IMG_W*IMG_H).

Ports:
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  synchronous active-low reset.
- START  in  1  one-cycle pulse; begins a frame when idle.
- PIX_VALID  in  1  pixel present.
- PIX_IN  in  PIX_W  pixel value.
- PIX_READY  out  1  block can accept a pixel.
- OUT_VALID  out  1  integral value present.
- OUT_READY  in  1  downstream accepts.
- OUT_DATA  out  ACC_W  integral value.
- OUT_X  out  clog2(IMG_W)  column of OUT_DATA.
- OUT_Y  out  clog2(IMG_H)  row of OUT_DATA.
- BUSY  out  1  frame in progress.
- DONE  out  1  one-cycle pulse on the handshake of the last output.

Behaviour:
- Reset: all sampled on CLK while RESET_N=0. State=IDLE. PIX_READY=0, OUT_VALID=0, OUT_DATA=0, OUT_X=0, OUT_Y=0, BUSY=0, DONE=0. Column/row counters and row sum cleared. Line memory is not cleared.
- States:
  - IDLE -> RUN on START=1.
  - RUN -> FLUSH when the last pixel (x=IMG_W-1, y=IMG_H-1) is accepted.
  - FLUSH -> IDLE on the output handshake of that pixel; DONE=1 in that cycle.
- START outside IDLE is ignored.
- PIX_READY = (state==RUN) && (!OUT_VALID || OUT_READY). Input handshake = PIX_VALID && PIX_READY.
- Term t = SQUARED ? PIX_IN*PIX_IN : PIX_IN, zero-extended to ACC_W.
- On input handshake at (x,y):
  - new_row = (x==0 ? 0 : row_sum) + t.
  - above = (y==0 ? 0 : line[x]). Stale line-memory content must never leak into row 0.
  - OUT_DATA <= above + new_row; line[x] <= above + new_row; row_sum <= new_row.
  - OUT_X <= x, OUT_Y <= y, OUT_VALID <= 1.
  - Advance x; when x wraps at IMG_W-1, x <= 0 and y increments.
- Latency: exactly 1 cycle from input handshake to OUT_VALID.
- Throughput: 1 pixel/cycle while OUT_READY stays high.
- OUT_VALID/OUT_DATA/OUT_X/OUT_Y hold stable while OUT_VALID && !OUT_READY. OUT_VALID clears on output handshake unless a new input is accepted in the same cycle.
- Arithmetic: unsigned, ACC_W bits. Sized so that all-max pixels never overflow; no saturation logic.
- Line memory: IMG_W x ACC_W, combinational read, single write per cycle. A register array or distributed RAM is acceptable.
- Reset mid-frame: abort immediately to IDLE. No DONE pulse. The next frame after START is unaffected by stale line data.
- BUSY = (state != IDLE).

Decomposition:
- Package integral_pkg: clog2 helper function, ACC_W computation function, state enum {IDLE, RUN, FLUSH}.
- One sub-module: integral_line_mem (parametrised depth/width, combinational read, synchronous write).
- Counters, FSM and datapath stay in the top module.

Test Plan:
- 4x3 frame, all pixels 1, OUT_READY=1 -> OUT_DATA=(x+1)*(y+1); last value 12; DONE pulses once, 1 cycle after the last input.
- Default 20x20, PIX_W=8, all pixels 255 -> final OUT_DATA=102000 with no overflow; a second frame gives identical results (no stale leakage).
- Random OUT_READY (50%), random PIX_VALID gaps -> outputs match the reference model in order; data stable while stalled; no pixel lost or duplicated.
- SQUARED=1, 4x3, pixel = x+1 -> row 0 outputs 1,5,14,30; row 2, x=3 output = 90.
- START pulsed during RUN -> ignored; counters and outputs continue unchanged.
- RESET_N low for 1 cycle mid-frame at (x=2, y=1) -> all outputs zero, BUSY=0, no DONE. A new frame of all 2s yields 2*(x+1)*(y+1).

Source files
------------

// File: rtl/integral_pkg.sv
// Shared helpers and types for the streaming integral-image generator.
package integral_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Widest possible sum: every pixel at full scale over the whole frame.
  function automatic int acc_width(input int pix_w, input int squared, input int img_w,
                                   input int img_h);
    return ((squared != 0) ? 2 * pix_w : pix_w) + clog2(img_w * img_h);
  endfunction

endpackage

// File: rtl/integral_line_mem.sv
// One-row line store: combinational read, single synchronous write, no reset.
module integral_line_mem
  import integral_pkg::*;
#(
  parameter int DEPTH = 20,
  parameter int WIDTH = 17
) (
  input  logic                      CLK,
  input  logic                      we_i,
  input  logic [clog2(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]          wdata_i,
  input  logic [clog2(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]          rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/integral_image_stream.sv
// Streaming integral image: one pixel in, one II(x,y) out, one-cycle latency,
// with valid/ready on both sides and an IDLE/RUN/FLUSH frame sequencer.
module integral_image_stream
  import integral_pkg::*;
#(
  parameter int IMG_W   = 20,
  parameter int IMG_H   = 20,
  parameter int PIX_W   = 8,
  parameter int SQUARED = 0
) (
  input  logic                                              CLK,
  input  logic                                              RESET_N,
  input  logic                                              START,
  input  logic                                              PIX_VALID,
  input  logic [PIX_W-1:0]                                  PIX_IN,
  output logic                                              PIX_READY,
  output logic                                              OUT_VALID,
  input  logic                                              OUT_READY,
  output logic [acc_width(PIX_W, SQUARED, IMG_W, IMG_H)-1:0] OUT_DATA,
  output logic [clog2(IMG_W)-1:0]                           OUT_X,
  output logic [clog2(IMG_H)-1:0]                           OUT_Y,
  output logic                                              BUSY,
  output logic                                              DONE
);

  localparam int ACC_W = acc_width(PIX_W, SQUARED, IMG_W, IMG_H);
  localparam int XW    = clog2(IMG_W);
  localparam int YW    = clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  state_e             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [ACC_W-1:0]   row_sum_q, row_sum_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic [XW-1:0]      out_x_q, out_x_d;
  logic [YW-1:0]      out_y_q, out_y_d;

  logic               pix_ready_s, in_hs_s, out_hs_s, last_pix_s;
  logic [2*PIX_W-1:0] sq_s;
  logic [ACC_W-1:0]   term_s, row_base_s, new_row_s, above_s, sum_s, line_rd_s;

  integral_line_mem #(
    .DEPTH (IMG_W),
    .WIDTH (ACC_W)
  ) u_line_mem (
    .CLK     (CLK),
    .we_i    (in_hs_s),
    .waddr_i (x_q),
    .wdata_i (sum_s),
    .raddr_i (x_q),
    .rdata_o (line_rd_s)
  );

  assign in_hs_s    = PIX_VALID && pix_ready_s;
  assign out_hs_s   = out_valid_q && OUT_READY;
  assign last_pix_s = (x_q == X_LAST) && (y_q == Y_LAST);

  // The y==0 guard keeps a previous (or aborted) frame's line data out of row 0.
  assign sq_s       = PIX_IN * PIX_IN;
  assign term_s     = (SQUARED != 0) ? ACC_W'(sq_s) : ACC_W'(PIX_IN);
  assign row_base_s = (x_q == '0) ? '0 : row_sum_q;
  assign new_row_s  = row_base_s + term_s;
  assign above_s    = (y_q == '0) ? '0 : line_rd_s;
  assign sum_s      = above_s + new_row_s;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = START ? RUN : IDLE;
      RUN:     state_d = (in_hs_s && last_pix_s) ? FLUSH : RUN;
      FLUSH:   state_d = out_hs_s ? IDLE : FLUSH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix_ready_s = (state_q == RUN) && (!out_valid_q || OUT_READY);
    BUSY        = (state_q != IDLE);
    DONE        = (state_q == FLUSH) && out_hs_s;
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    row_sum_d   = row_sum_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    if (in_hs_s) begin
      row_sum_d   = new_row_s;
      out_valid_d = 1'b1;
      out_data_d  = sum_s;
      out_x_d     = x_q;
      out_y_d     = y_q;
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end else if (out_hs_s) begin
      out_valid_d = 1'b0;
    end else if ((state_q == IDLE) && START) begin
      x_d       = '0;
      y_d       = '0;
      row_sum_d = '0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      x_q         <= '0;
      y_q         <= '0;
      row_sum_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      row_sum_q   <= row_sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  assign PIX_READY = pix_ready_s;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_X     = out_x_q;
  assign OUT_Y     = out_y_q;

endmodule

// File: tb/tb_integral_image_stream.sv
// Bench for integral_image_stream: three instances (4x3 plain, 20x20 plain, 4x3 squared)
// checked against a brute-force double-sum reference.
module tb_integral_image_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic       a_start, a_pv, a_prdy, a_ov, a_ordy, a_busy, a_done;
  logic [7:0] a_pin;
  logic [11:0] a_od;
  logic [1:0] a_ox, a_oy;

  logic       b_start, b_pv, b_prdy, b_ov, b_ordy, b_busy, b_done;
  logic [7:0] b_pin;
  logic [16:0] b_od;
  logic [4:0] b_ox, b_oy;

  logic       c_start, c_pv, c_prdy, c_ov, c_ordy, c_busy, c_done;
  logic [7:0] c_pin;
  logic [19:0] c_od;
  logic [1:0] c_ox, c_oy;

  integral_image_stream #(.IMG_W(4), .IMG_H(3), .PIX_W(8), .SQUARED(0)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .START(a_start), .PIX_VALID(a_pv), .PIX_IN(a_pin),
    .PIX_READY(a_prdy), .OUT_VALID(a_ov), .OUT_READY(a_ordy), .OUT_DATA(a_od),
    .OUT_X(a_ox), .OUT_Y(a_oy), .BUSY(a_busy), .DONE(a_done));

  integral_image_stream #(.IMG_W(20), .IMG_H(20), .PIX_W(8), .SQUARED(0)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .START(b_start), .PIX_VALID(b_pv), .PIX_IN(b_pin),
    .PIX_READY(b_prdy), .OUT_VALID(b_ov), .OUT_READY(b_ordy), .OUT_DATA(b_od),
    .OUT_X(b_ox), .OUT_Y(b_oy), .BUSY(b_busy), .DONE(b_done));

  integral_image_stream #(.IMG_W(4), .IMG_H(3), .PIX_W(8), .SQUARED(1)) dut_c (
    .CLK(clk), .RESET_N(rst_n), .START(c_start), .PIX_VALID(c_pv), .PIX_IN(c_pin),
    .PIX_READY(c_prdy), .OUT_VALID(c_ov), .OUT_READY(c_ordy), .OUT_DATA(c_od),
    .OUT_X(c_ox), .OUT_Y(c_oy), .BUSY(c_busy), .DONE(c_done));

  task automatic test_reset();
    rst_n = 1'b0;
    a_start = 1'b0; a_pv = 1'b0; a_pin = 8'd0; a_ordy = 1'b1;
    b_start = 1'b0; b_pv = 1'b0; b_pin = 8'd0; b_ordy = 1'b1;
    c_start = 1'b0; c_pv = 1'b0; c_pin = 8'd0; c_ordy = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a_prdy, a_ov, a_busy, a_done, a_od, a_ox, a_oy} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_a got prdy=%b ov=%b busy=%b done=%b data=%0d x=%0d y=%0d, want all 0",
               a_prdy, a_ov, a_busy, a_done, a_od, a_ox, a_oy);
    end
    n_cmp++;
    if ({b_prdy, b_ov, b_busy, b_done, b_od, b_ox, b_oy} !== 31'd0) begin
      n_err++;
      $display("FAIL reset_b got prdy=%b ov=%b busy=%b done=%b data=%0d x=%0d y=%0d, want all 0",
               b_prdy, b_ov, b_busy, b_done, b_od, b_ox, b_oy);
    end
    n_cmp++;
    if ({c_prdy, c_ov, c_busy, c_done, c_od, c_ox, c_oy} !== 28'd0) begin
      n_err++;
      $display("FAIL reset_c got prdy=%b ov=%b busy=%b done=%b data=%0d x=%0d y=%0d, want all 0",
               c_prdy, c_ov, c_busy, c_done, c_od, c_ox, c_oy);
    end
    rst_n = 1'b1;
  endtask

  // One 4x3 frame on dut_a. mode 0: every pixel = cval, mode 1: random pixels.
  // abort_at >= 0 pulls reset after that many pixels have been accepted.
  task automatic run_a(input string tag, input int mode, input int cval, input bit stall,
                       input bit start_mid, input int abort_at);
    logic [7:0]  pix  [12];
    logic [31:0] expv [12];
    int pi, oi, cyc, n_done, s;
    bit prev_stall, exp_done;
    logic [11:0] h_od;
    logic [1:0]  h_ox, h_oy;
    for (int k = 0; k < 12; k++) begin
      pix[k] = (mode == 0) ? 8'(cval) : 8'($urandom_range(0, 255));
    end
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        s = 0;
        for (int j = 0; j <= y; j++) begin
          for (int i = 0; i <= x; i++) begin
            s += int'(pix[j*4+i]);
          end
        end
        expv[y*4+x] = 32'(s);
      end
    end
    @(negedge clk);
    a_start = 1'b1; a_pv = 1'b0; a_ordy = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    pi = 0; oi = 0; cyc = 0; n_done = 0; prev_stall = 1'b0;
    h_od = 12'd0; h_ox = 2'd0; h_oy = 2'd0;
    while (oi < 12 && cyc < 400 && !(abort_at >= 0 && pi == abort_at)) begin
      a_pv    = (pi < 12) && (!stall || ($urandom_range(0, 2) != 0));
      a_pin   = (pi < 12) ? pix[pi] : 8'd0;
      a_ordy  = !stall || ($urandom_range(0, 1) == 1);
      a_start = start_mid && (pi == 5);
      #1;
      if (prev_stall) begin
        n_cmp++;
        if (a_ov !== 1'b1 || a_od !== h_od || a_ox !== h_ox || a_oy !== h_oy) begin
          n_err++;
          $display("FAIL %s stall_hold got v=%b d=%0d x=%0d y=%0d, want v=1 d=%0d x=%0d y=%0d",
                   tag, a_ov, a_od, a_ox, a_oy, h_od, h_ox, h_oy);
        end
      end
      exp_done = (a_ov === 1'b1) && a_ordy && (oi == 11);
      n_cmp++;
      if (a_done !== exp_done) begin
        n_err++;
        $display("FAIL %s done got %b want %b (output %0d)", tag, a_done, exp_done, oi);
      end
      if (a_done === 1'b1) n_done++;
      if (a_ov === 1'b1 && a_ordy) begin
        n_cmp++;
        if (32'(a_od) !== expv[oi] || a_ox !== 2'(oi % 4) || a_oy !== 2'(oi / 4)) begin
          n_err++;
          $display("FAIL %s out[%0d] got d=%0d x=%0d y=%0d, want d=%0d x=%0d y=%0d",
                   tag, oi, a_od, a_ox, a_oy, expv[oi], oi % 4, oi / 4);
        end
        oi++;
      end
      prev_stall = (a_ov === 1'b1) && !a_ordy;
      h_od = a_od; h_ox = a_ox; h_oy = a_oy;
      if (a_pv && a_prdy === 1'b1) pi++;
      @(negedge clk);
      cyc++;
    end
    a_pv = 1'b0; a_start = 1'b0; a_ordy = 1'b1;
    if (abort_at >= 0) begin
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({a_prdy, a_ov, a_busy, a_done, a_od, a_ox, a_oy} !== 20'd0) begin
        n_err++;
        $display("FAIL %s abort_state got prdy=%b ov=%b busy=%b done=%b d=%0d x=%0d y=%0d, want 0",
                 tag, a_prdy, a_ov, a_busy, a_done, a_od, a_ox, a_oy);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        n_cmp++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
          n_err++;
          $display("FAIL %s abort_quiet got done=%b busy=%b want 0 0", tag, a_done, a_busy);
        end
      end
      n_cmp++;
      if (n_done != 0) begin
        n_err++;
        $display("FAIL %s abort_done_count got %0d want 0", tag, n_done);
      end
    end else begin
      n_cmp++;
      if (oi != 12 || pi != 12) begin
        n_err++;
        $display("FAIL %s count got in=%0d out=%0d want 12 12 (cycles %0d)", tag, pi, oi, cyc);
      end
      n_cmp++;
      if (n_done != 1) begin
        n_err++;
        $display("FAIL %s done_count got %0d want 1", tag, n_done);
      end
      n_cmp++;
      if (a_busy !== 1'b0 || a_ov !== 1'b0) begin
        n_err++;
        $display("FAIL %s idle_after got busy=%b ov=%b want 0 0", tag, a_busy, a_ov);
      end
    end
  endtask

  task automatic test_all_ones();
    run_a("ones", 0, 1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random_stall();
    for (int r = 0; r < 4; r++) run_a("rand_stall", 1, 0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_start_during_run();
    run_a("start_mid", 1, 0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_reset_mid_frame();
    run_a("abort", 1, 0, 1'b0, 1'b0, 6);
    run_a("twos", 0, 2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_all_max(input int frame);
    int pi, oi, cyc, n_done;
    logic [31:0] expd, last;
    @(negedge clk);
    b_start = 1'b1; b_pv = 1'b0; b_ordy = 1'b1; b_pin = 8'd255;
    @(negedge clk);
    b_start = 1'b0;
    pi = 0; oi = 0; cyc = 0; n_done = 0; last = 32'd0;
    while (oi < 400 && cyc < 1000) begin
      b_pv = (pi < 400);
      #1;
      if (b_done === 1'b1) n_done++;
      if (b_ov === 1'b1 && b_ordy) begin
        expd = 32'(255 * (oi % 20 + 1) * (oi / 20 + 1));
        n_cmp++;
        if (32'(b_od) !== expd || b_ox !== 5'(oi % 20) || b_oy !== 5'(oi / 20)) begin
          n_err++;
          $display("FAIL max%0d out[%0d] got d=%0d x=%0d y=%0d, want d=%0d x=%0d y=%0d",
                   frame, oi, b_od, b_ox, b_oy, expd, oi % 20, oi / 20);
        end
        last = 32'(b_od);
        oi++;
      end
      if (b_pv && b_prdy === 1'b1) pi++;
      @(negedge clk);
      cyc++;
    end
    b_pv = 1'b0;
    n_cmp++;
    if (oi != 400 || last !== 32'd102000) begin
      n_err++;
      $display("FAIL max%0d final got outputs=%0d last=%0d want 400 102000", frame, oi, last);
    end
    n_cmp++;
    if (n_done != 1 || b_busy !== 1'b0) begin
      n_err++;
      $display("FAIL max%0d done got pulses=%0d busy=%b want 1 0", frame, n_done, b_busy);
    end
  endtask

  task automatic test_squared();
    logic [31:0] expv [12];
    int pi, oi, cyc, s;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        s = 0;
        for (int j = 0; j <= y; j++) begin
          for (int i = 0; i <= x; i++) begin
            s += (i + 1) * (i + 1);
          end
        end
        expv[y*4+x] = 32'(s);
      end
    end
    @(negedge clk);
    c_start = 1'b1; c_pv = 1'b0; c_ordy = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    pi = 0; oi = 0; cyc = 0;
    while (oi < 12 && cyc < 200) begin
      c_pv  = (pi < 12);
      c_pin = 8'(pi % 4 + 1);
      #1;
      if (c_ov === 1'b1 && c_ordy) begin
        n_cmp++;
        if (32'(c_od) !== expv[oi] || c_ox !== 2'(oi % 4) || c_oy !== 2'(oi / 4)) begin
          n_err++;
          $display("FAIL squared out[%0d] got d=%0d x=%0d y=%0d, want d=%0d x=%0d y=%0d",
                   oi, c_od, c_ox, c_oy, expv[oi], oi % 4, oi / 4);
        end
        if (oi == 11) begin
          n_cmp++;
          if (32'(c_od) !== 32'd90) begin
            n_err++;
            $display("FAIL squared corner got %0d want 90", c_od);
          end
        end
        oi++;
      end
      if (c_pv && c_prdy === 1'b1) pi++;
      @(negedge clk);
      cyc++;
    end
    c_pv = 1'b0;
    n_cmp++;
    if (oi != 12 || c_busy !== 1'b0) begin
      n_err++;
      $display("FAIL squared end got outputs=%0d busy=%b want 12 0", oi, c_busy);
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_random_stall();
    test_start_during_run();
    test_reset_mid_frame();
    test_all_max(0);
    test_all_max(1);
    test_squared();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
